viterbi_decoder: RTL and testbench

//  Hard-decision Viterbi decoder for a rate-1/2, K=3 convolutional code (g0=111, g1=101).

---
 rtl/viterbi_pkg.sv | 19 +
 rtl/conv_encoder.sv | 35 +++
 rtl/viterbi_decoder.sv | 99 +++++++++
 tb/tb_viterbi_decoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants and code-symbol function for the K=3 rate-1/2 link
package viterbi_pkg;

  localparam int         K       = 3;
  localparam int         NSTATES = 2 ** (K - 1);
  localparam logic [2:0] G0      = 3'b111;
  localparam logic [2:0] G1      = 3'b101;
  localparam int         L       = 16;
  localparam int         PMW     = 7;

  // Code symbol {c1,c0} produced from state {s1,s0} when input bit u is shifted in.
  // The tap vector is {u,s1,s0}; c1 uses G0 and c0 uses G1.
  function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic u);
    logic [2:0] taps;
    taps = {u, state};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - companion K=3 rate-1/2 convolutional encoder, one-cycle latency
module conv_encoder
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       valid_o,
  output logic [1:0] d_out
);

  logic [1:0] state_q;
  logic [1:0] sym_q;
  logic       valid_q;

  // Shift the input bit into {s1,s0} and register the matching code symbol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= 2'b00;
      sym_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      valid_q <= enable_i;
      if (enable_i) begin
        sym_q   <= exp_sym(state_q, d_in);
        state_q <= {d_in, state_q[1]};
      end
    end
  end

  assign valid_o = valid_q;
  assign d_out   = sym_q;

endmodule

// File: rtl/viterbi_decoder.sv
// rtl/viterbi_decoder.sv - hard-decision K=3 Viterbi decoder with register-exchange survivors
module viterbi_decoder #(
  parameter int L   = viterbi_pkg::L,
  parameter int PMW = viterbi_pkg::PMW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out
);
  import viterbi_pkg::*;

  localparam int             NS       = NSTATES;
  localparam logic [PMW-1:0] PM_START = PMW'(16);
  localparam logic [PMW-1:0] PM_SAT   = '1;

  // The oldest survivor bit is consumed as d_out in the same cycle it would be
  // written, so only L-1 bits per state are actually held in flops.
  logic [PMW-1:0] pm_q   [NS];
  logic [PMW-1:0] pm_d   [NS];
  logic [PMW-1:0] acs_pm [NS];
  logic [L-2:0]   surv_q [NS];
  logic [L-1:0]   surv_d [NS];
  logic [PMW-1:0] min_pm;
  logic [1:0]     best;
  logic           d_out_q;
  logic           d_out_d;

  // One add-compare-select per next state ns = {u,a}; predecessors are {a,0} and {a,1}.
  for (genvar g = 0; g < NS; g++) begin : g_acs
    localparam logic       U  = 1'((g >> 1) & 1);
    localparam logic       A  = 1'(g & 1);
    localparam logic [1:0] P0 = {A, 1'b0};
    localparam logic [1:0] P1 = {A, 1'b1};

    logic [1:0]   x0;
    logic [1:0]   x1;
    logic [1:0]   bm0;
    logic [1:0]   bm1;
    logic [PMW:0] cand0;
    logic [PMW:0] cand1;
    logic [PMW:0] win;
    logic         take1;

    assign x0    = d_in ^ exp_sym(P0, U);
    assign x1    = d_in ^ exp_sym(P1, U);
    assign bm0   = {1'b0, x0[1]} + {1'b0, x0[0]};
    assign bm1   = {1'b0, x1[1]} + {1'b0, x1[0]};
    assign cand0 = {1'b0, pm_q[P0]} + {{(PMW - 1){1'b0}}, bm0};
    assign cand1 = {1'b0, pm_q[P1]} + {{(PMW - 1){1'b0}}, bm1};
    // Ties go to the predecessor with s0 = 0.
    assign take1 = cand1 < cand0;
    assign win   = take1 ? cand1 : cand0;
    // Normalization keeps metrics small; clamp only as a guard against overflow.
    assign acs_pm[g] = win[PMW] ? PM_SAT : win[PMW-1:0];
    assign surv_d[g] = {take1 ? surv_q[P1] : surv_q[P0], U};
  end

  // Find the best state; strict compare keeps the lowest index on ties.
  always_comb begin
    min_pm = acs_pm[0];
    best   = 2'd0;
    for (int i = 1; i < NS; i++) begin
      if (acs_pm[i] < min_pm) begin
        min_pm = acs_pm[i];
        best   = 2'(i);
      end
    end
  end

  // Rebase all metrics on the minimum and pick the oldest bit of the best survivor.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      pm_d[i] = acs_pm[i] - min_pm;
    end
    d_out_d = surv_d[best][L-1];
  end

  // Metrics, survivors and output advance only on enabled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NS; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_START;
        surv_q[i] <= '0;
      end
      d_out_q <= 1'b0;
    end else if (enable) begin
      for (int i = 0; i < NS; i++) begin
        pm_q[i]   <= pm_d[i];
        surv_q[i] <= surv_d[i][L-2:0];
      end
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb/tb_viterbi_decoder.sv - randomized encoder->decoder link bench with delayed-input reference
module tb_viterbi_decoder;

  localparam int LD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enc_en = 1'b0;
  logic       enc_d = 1'b0;
  logic       enc_valid;
  logic [1:0] enc_sym;
  logic [1:0] flip = 2'b00;
  logic [1:0] dec_d_in;
  logic       d_out;

  int errors = 0;
  int checks = 0;

  bit   sent[$];
  int   nproc = 0;
  logic hold = 1'b0;
  logic en_edge = 1'b0;
  int   flip_at = -1;
  int   burst_lo = -1;
  int   burst_hi = -2;
  int   skip_lo = -1;
  int   skip_hi = -2;

  always #5 clk = ~clk;

  assign dec_d_in = enc_sym ^ flip;

  conv_encoder u_enc (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enc_en),
    .d_in     (enc_d),
    .valid_o  (enc_valid),
    .d_out    (enc_sym)
  );

  viterbi_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enc_valid),
    .d_in   (dec_d_in),
    .d_out  (d_out)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: check the output of the edge just past against the delayed
  // input stream, then drive the encoder for the next edge.
  task automatic cycle(input logic en, input logic b);
    logic exp_bit;
    int   j;
    @(negedge clk);
    if (en_edge) begin
      j       = nproc - (LD - 1);
      exp_bit = (j >= 0) ? sent[j] : 1'b0;
      nproc++;
      hold = exp_bit;
      if (!(j >= skip_lo && j <= skip_hi)) check("dout", 32'(d_out), 32'(exp_bit));
    end else begin
      check("dout_hold", 32'(d_out), 32'(hold));
    end
    en_edge = enc_valid;
    flip = 2'b00;
    if (enc_valid && nproc == flip_at) flip = 2'b01;
    if (enc_valid && nproc >= burst_lo && nproc <= burst_hi) flip = 2'b11;
    enc_en = en;
    enc_d  = b;
    if (en) sent.push_back(b);
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    enc_en = 1'b0;
    flip   = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_dout", 32'(d_out), 0);
    check("rst_pm0", 32'(dut.pm_q[0]), 0);
    check("rst_pm1", 32'(dut.pm_q[1]), 16);
    check("rst_pm2", 32'(dut.pm_q[2]), 16);
    check("rst_pm3", 32'(dut.pm_q[3]), 16);
    check("rst_surv0", 32'(dut.surv_q[0]), 0);
    check("rst_surv3", 32'(dut.surv_q[3]), 0);
    check("rst_valid", 32'(enc_valid), 0);
    check("rst_sym", 32'(enc_sym), 0);
    sent.delete();
    nproc   = 0;
    hold    = 1'b0;
    en_edge = 1'b0;
    rst     = 1'b1;
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'($urandom_range(0, 1)));
  endtask

  function automatic int pm_min();
    int m;
    m = dut.pm_q[0];
    if (dut.pm_q[1] < m) m = dut.pm_q[1];
    if (dut.pm_q[2] < m) m = dut.pm_q[2];
    if (dut.pm_q[3] < m) m = dut.pm_q[3];
    return m;
  endfunction

  initial begin
    bit         enc_in  [5];
    logic [1:0] enc_exp [5];
    bit         s1;
    bit         s0;

    do_reset();

    // Encoder: expected symbols from c1 = u+s1+s0, c0 = u+s0 (mod 2).
    enc_in = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    s1 = 1'b0;
    s0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enc_exp[i] = {1'((int'(enc_in[i]) + int'(s1) + int'(s0)) % 2),
                    1'((int'(enc_in[i]) + int'(s0)) % 2)};
      s0 = s1;
      s1 = enc_in[i];
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) check("enc_valid_pre", 32'(enc_valid), 0);
      else begin
        check("enc_sym", 32'(enc_sym), 32'(enc_exp[i-1]));
        check("enc_valid", 32'(enc_valid), 1);
      end
      enc_en = 1'b1;
      enc_d  = enc_in[i];
    end
    @(negedge clk);
    check("enc_sym_last", 32'(enc_sym), 32'(enc_exp[4]));
    enc_en = 1'b0;
    enc_d  = 1'b1;
    @(negedge clk);
    check("enc_valid_off", 32'(enc_valid), 0);
    check("enc_sym_hold", 32'(enc_sym), 32'(enc_exp[4]));

    // All-zero stream: output stays 0 and the zero state keeps metric 0.
    do_reset();
    for (int i = 0; i < 64 + LD; i++) begin
      cycle(1'b1, 1'b0);
      check("pm0_zero", 32'(dut.pm_q[0]), 0);
    end

    // Random stream over a clean channel.
    do_reset();
    run_random(256 + LD);

    // Single bit error on symbol 40.
    do_reset();
    flip_at = 40;
    for (int i = 0; i < 128 + LD; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)));
      if (nproc == 42) check("pm_min_after_flip", pm_min(), 0);
    end
    check("pm_min_end", pm_min(), 0);
    flip_at = -1;

    // Enable toggling every other cycle.
    do_reset();
    for (int i = 0; i < 2 * (128 + LD); i++) begin
      cycle(i % 2 == 0, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a stream, then restart from state 0.
    do_reset();
    run_random(100);
    do_reset();
    run_random(64 + LD);

    // Two-symbol burst: outputs near the burst are not judged, later ones must be exact.
    do_reset();
    burst_lo = 60;
    burst_hi = 61;
    skip_lo  = 60 - LD;
    skip_hi  = 61 + LD;
    run_random(160 + LD);
    burst_lo = -1;
    burst_hi = -2;
    skip_lo  = -1;
    skip_hi  = -2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
